// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM arbiter. These sit next to the mobo state definitions.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VGA = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts posedges spent in ACCESS; expired is high on the TIMEOUT_CYCLES-th one.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/VGA) arbiter for the single mobo RAM port: one access at a time,
// VGA priority with a bounded burst while the CPU waits, and a RAM response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned VGA_BURST_MAX  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    input  logic              vga_req,
    input  logic              vga_we,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_done,
    output logic              vga_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              busy
);

    localparam int unsigned BURST_W = $clog2(VGA_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(VGA_BURST_MAX);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                err_q, err_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vga_rdata_q, vga_rdata_d;
    logic                grant;
    logic                cpu_wins;
    logic                expired;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  (state_q == ARB_ACCESS),
        .expired (expired)
    );

    // VGA wins ties unless it has used up its burst allowance while the CPU waits.
    assign cpu_wins = cpu_req && (!vga_req || (burst_q == BURST_LIMIT));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        burst_d     = burst_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        grant       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (cpu_wins) begin
                    grant       = 1'b1;
                    state_d     = ARB_ACCESS;
                    owner_d     = OWN_CPU;
                    err_d       = 1'b0;
                    burst_d     = '0;
                    ram_we_d    = cpu_we;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                end else if (vga_req) begin
                    grant       = 1'b1;
                    state_d     = ARB_ACCESS;
                    owner_d     = OWN_VGA;
                    err_d       = 1'b0;
                    if (!cpu_req) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_LIMIT) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                    ram_we_d    = vga_we;
                    ram_addr_d  = vga_addr;
                    ram_wdata_d = vga_wdata;
                end
            end
            ARB_ACCESS: begin
                if (ram_ready) begin
                    state_d = ARB_DONE;
                    if (owner_q == OWN_CPU) cpu_rdata_d = ram_rdata;
                    else                    vga_rdata_d = ram_rdata;
                end else if (expired) begin
                    state_d = ARB_DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_CPU) cpu_rdata_d = '0;
                    else                    vga_rdata_d = '0;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_CPU;
            err_q       <= 1'b0;
            burst_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            burst_q     <= burst_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

    // Strobes decode directly from registered state, so they are glitch-free and clear on reset.
    assign ram_en    = (state_q == ARB_ACCESS);
    assign busy      = (state_q != ARB_IDLE);
    assign cpu_done  = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
    assign vga_done  = (state_q == ARB_DONE) && (owner_q == OWN_VGA);
    assign cpu_err   = cpu_done && err_q;
    assign vga_err   = vga_done && err_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus sequences for
// contention, timeout and reset during an access.
module tb_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err;
    logic        vga_req = 1'b0, vga_we = 1'b0;
    logic [31:0] vga_addr = '0, vga_wdata = '0;
    logic [31:0] vga_rdata;
    logic        vga_done, vga_err;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ready = 1'b0;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

    mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .VGA_BURST_MAX  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .vga_req   (vga_req),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_wdata (vga_wdata),
        .vga_rdata (vga_rdata),
        .vga_done  (vga_done),
        .vga_err   (vga_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic creq, cwe; logic [31:0] caddr, cwd;
        logic vreq, vwe; logic [31:0] vaddr, vwd;
        logic rdy;       logic [31:0] rrd;
    } in_t;

    typedef struct {
        logic en, we; logic [31:0] addr, wd;
        logic cdone, cerr; logic [31:0] crd;
        logic vdone, verr; logic [31:0] vrd;
        logic busy;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check1 ({name, " ram_en"},    ram_en,    L);
        check1 ({name, " ram_we"},    ram_we,    L);
        check32({name, " ram_addr"},  ram_addr,  32'h0);
        check32({name, " ram_wdata"}, ram_wdata, 32'h0);
        check1 ({name, " cpu_done"},  cpu_done,  L);
        check1 ({name, " cpu_err"},   cpu_err,   L);
        check32({name, " cpu_rdata"}, cpu_rdata, 32'h0);
        check1 ({name, " vga_done"},  vga_done,  L);
        check1 ({name, " vga_err"},   vga_err,   L);
        check32({name, " vga_rdata"}, vga_rdata, 32'h0);
        check1 ({name, " busy"},      busy,      L);
    endtask

    initial begin
        // Inputs are applied before an edge; expectations describe the state after it.
        vecs[0]  = '{"cpu_rd_grant", '{H,L,32'h100,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{H,L,32'h100,32'h0, L,L,32'h0, L,L,32'h0, H}};
        vecs[1]  = '{"cpu_rd_wait", '{H,L,32'h100,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{H,L,32'h100,32'h0, L,L,32'h0, L,L,32'h0, H}};
        vecs[2]  = '{"cpu_rd_done", '{H,L,32'h100,32'h0, L,L,32'h0,32'h0, H,32'hDEADBEEF},
                     '{L,L,32'h0,32'h0, H,L,32'hDEADBEEF, L,L,32'h0, H}};
        vecs[3]  = '{"cpu_rd_idle", '{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{L,L,32'h0,32'h0, L,L,32'hDEADBEEF, L,L,32'h0, L}};
        vecs[4]  = '{"vga_wr_grant", '{L,L,32'h0,32'h0, H,H,32'h2000,32'h12345678, L,32'h0},
                     '{H,H,32'h2000,32'h12345678, L,L,32'hDEADBEEF, L,L,32'h0, H}};
        vecs[5]  = '{"vga_wr_wait1", '{L,L,32'h0,32'h0, H,H,32'h2000,32'h12345678, L,32'h0},
                     '{H,H,32'h2000,32'h12345678, L,L,32'hDEADBEEF, L,L,32'h0, H}};
        vecs[6]  = '{"vga_wr_wait2", '{L,L,32'h0,32'h0, H,H,32'h2000,32'h12345678, L,32'h0},
                     '{H,H,32'h2000,32'h12345678, L,L,32'hDEADBEEF, L,L,32'h0, H}};
        vecs[7]  = '{"vga_wr_done", '{L,L,32'h0,32'h0, H,H,32'h2000,32'h12345678, H,32'hA5A5A5A5},
                     '{L,L,32'h0,32'h0, L,L,32'hDEADBEEF, H,L,32'hA5A5A5A5, H}};
        vecs[8]  = '{"vga_wr_idle", '{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{L,L,32'h0,32'h0, L,L,32'hDEADBEEF, L,L,32'hA5A5A5A5, L}};
        vecs[9]  = '{"cpu_wr_grant", '{H,H,32'h10,32'hCAFEF00D, L,L,32'h0,32'h0, L,32'h0},
                     '{H,H,32'h10,32'hCAFEF00D, L,L,32'hDEADBEEF, L,L,32'hA5A5A5A5, H}};
        vecs[10] = '{"cpu_in_change", '{H,L,32'h20,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{H,H,32'h10,32'hCAFEF00D, L,L,32'hDEADBEEF, L,L,32'hA5A5A5A5, H}};
        vecs[11] = '{"cpu_wr_done", '{H,L,32'h20,32'h0, L,L,32'h0,32'h0, H,32'h11112222},
                     '{L,L,32'h0,32'h0, H,L,32'h11112222, L,L,32'hA5A5A5A5, H}};
        vecs[12] = '{"cpu_wr_idle", '{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{L,L,32'h0,32'h0, L,L,32'h11112222, L,L,32'hA5A5A5A5, L}};
        vecs[13] = '{"cpu_rd2_grant", '{H,L,32'h300,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{H,L,32'h300,32'h0, L,L,32'h11112222, L,L,32'hA5A5A5A5, H}};
        vecs[14] = '{"no_preempt", '{H,L,32'h300,32'h0, H,L,32'h400,32'h0, H,32'h33334444},
                     '{L,L,32'h0,32'h0, H,L,32'h33334444, L,L,32'hA5A5A5A5, H}};
        vecs[15] = '{"done_ign_req", '{L,L,32'h0,32'h0, H,L,32'h400,32'h0, L,32'h0},
                     '{L,L,32'h0,32'h0, L,L,32'h33334444, L,L,32'hA5A5A5A5, L}};
        vecs[16] = '{"vga_rd_grant", '{L,L,32'h0,32'h0, H,L,32'h400,32'h0, L,32'h0},
                     '{H,L,32'h400,32'h0, L,L,32'h33334444, L,L,32'hA5A5A5A5, H}};
        vecs[17] = '{"vga_rd_done", '{L,L,32'h0,32'h0, H,L,32'h400,32'h0, H,32'h55556666},
                     '{L,L,32'h0,32'h0, L,L,32'h33334444, H,L,32'h55556666, H}};
        vecs[18] = '{"vga_rd_idle", '{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L,32'h0},
                     '{L,L,32'h0,32'h0, L,L,32'h33334444, L,L,32'h55556666, L}};

        #2;
        check_all_zero("reset");
        #10;
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            cpu_req = vecs[k].i.creq;  cpu_we = vecs[k].i.cwe;
            cpu_addr = vecs[k].i.caddr; cpu_wdata = vecs[k].i.cwd;
            vga_req = vecs[k].i.vreq;  vga_we = vecs[k].i.vwe;
            vga_addr = vecs[k].i.vaddr; vga_wdata = vecs[k].i.vwd;
            ram_ready = vecs[k].i.rdy; ram_rdata = vecs[k].i.rrd;
            step();
            check1 ({vecs[k].name, " ram_en"},    ram_en,    vecs[k].e.en);
            if (vecs[k].e.en) begin
                check1 ({vecs[k].name, " ram_we"},    ram_we,    vecs[k].e.we);
                check32({vecs[k].name, " ram_addr"},  ram_addr,  vecs[k].e.addr);
                check32({vecs[k].name, " ram_wdata"}, ram_wdata, vecs[k].e.wd);
            end
            check1 ({vecs[k].name, " cpu_done"},  cpu_done,  vecs[k].e.cdone);
            check1 ({vecs[k].name, " cpu_err"},   cpu_err,   vecs[k].e.cerr);
            check32({vecs[k].name, " cpu_rdata"}, cpu_rdata, vecs[k].e.crd);
            check1 ({vecs[k].name, " vga_done"},  vga_done,  vecs[k].e.vdone);
            check1 ({vecs[k].name, " vga_err"},   vga_err,   vecs[k].e.verr);
            check32({vecs[k].name, " vga_rdata"}, vga_rdata, vecs[k].e.vrd);
            check1 ({vecs[k].name, " busy"},      busy,      vecs[k].e.busy);
        end

        // Contention: both held, RAM answers in the first ACCESS cycle.
        begin
            int ndone = 0;
            int cyc = 0;
            logic [1:0] want;
            cpu_req = H; cpu_we = L; cpu_addr = 32'hC00;
            vga_req = H; vga_we = L; vga_addr = 32'hB00;
            ram_ready = L; ram_rdata = 32'h0;
            while (ndone < 20 && cyc < 300) begin
                step();
                cyc++;
                ram_ready = ram_en;
                if (cpu_done || vga_done) begin
                    want = (ndone % 5 == 4) ? 2'b10 : 2'b01;
                    check32("contention order", {30'h0, cpu_done, vga_done}, {30'h0, want});
                    ndone++;
                    if (ndone == 20) begin
                        cpu_req = L;
                        vga_req = L;
                    end
                end
            end
            check32("contention count", ndone, 32'd20);
            ram_ready = L;
            step();
            check1("contention idle", busy, L);
        end

        // Timeout: CPU read never answered.
        begin
            int en_cycles = 0;
            cpu_req = H; cpu_we = L; cpu_addr = 32'h500;
            ram_ready = L;
            step();
            while (ram_en && en_cycles < 20) begin
                en_cycles++;
                step();
            end
            check32("timeout en cycles", en_cycles, 32'd8);
            check1 ("timeout cpu_done",  cpu_done,  H);
            check1 ("timeout cpu_err",   cpu_err,   H);
            check32("timeout cpu_rdata", cpu_rdata, 32'h0);
            check1 ("timeout vga_done",  vga_done,  L);
            cpu_req = L;
            step();
            vga_req = H; vga_we = L; vga_addr = 32'h600;
            step();
            check1 ("post-timeout vga en", ram_en, H);
            check32("post-timeout vga addr", ram_addr, 32'h600);
            ram_ready = H; ram_rdata = 32'h77778888;
            step();
            check1 ("post-timeout vga_done",  vga_done,  H);
            check1 ("post-timeout vga_err",   vga_err,   L);
            check32("post-timeout vga_rdata", vga_rdata, 32'h77778888);
            check1 ("post-timeout cpu_err",   cpu_err,   L);
            vga_req = L; ram_ready = L;
            step();
        end

        // Reset during ACCESS, then a held request completes after release.
        cpu_req = H; cpu_we = L; cpu_addr = 32'h700;
        step();
        check1("pre-reset ram_en", ram_en, H);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        ram_ready = H; ram_rdata = 32'h12121212;
        step();
        check1("in-reset cpu_done", cpu_done, L);
        check1("in-reset ram_en",   ram_en,   L);
        #3;
        rst = 1'b0;
        ram_ready = L;
        step();
        check1 ("re-req ram_en",   ram_en,   H);
        check32("re-req ram_addr", ram_addr, 32'h700);
        ram_ready = H; ram_rdata = 32'h9999AAAA;
        step();
        check1 ("re-req cpu_done",  cpu_done,  H);
        check1 ("re-req cpu_err",   cpu_err,   L);
        check32("re-req cpu_rdata", cpu_rdata, 32'h9999AAAA);
        cpu_req = L; ram_ready = L;
        step();
        check1("final idle", busy, L);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
